// File: rtl/xbus_sdram_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Package  : xbus_sdram_bridge_pkg
// Purpose  : Shared Xbus definitions for the SDRAM bridge: bus widths, the
//            default main-memory window limits, the watchdog width and the
//            bridge state encoding.
// Contents : XBUS_ADDR_W, XBUS_DATA_W, XBUS_DECODE_LIMIT, XBUS_RAM_LIMIT,
//            XBUS_TIMEOUT, XBUS_WDOG_W, state_t
// Revision : 1.0 - initial release
// ============================================================================
package xbus_sdram_bridge_pkg;

   localparam int XBUS_ADDR_W = 22;
   localparam int XBUS_DATA_W = 32;

   // Decoded window: octal 11000000 words. Populated RAM: octal 10000000 words.
   localparam logic [XBUS_ADDR_W-1:0] XBUS_DECODE_LIMIT = 22'h24_0000;
   localparam logic [XBUS_ADDR_W-1:0] XBUS_RAM_LIMIT    = 22'h20_0000;

   localparam int XBUS_TIMEOUT = 255;
   localparam int XBUS_WDOG_W  = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_ACK   = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/xbus_sdram_bridge_if.sv
`default_nettype none
// ============================================================================
// Interface: xbus_sdram_bridge_if
// Purpose  : Bundles the Xbus slave signals and the SDRAM-controller
//            handshake seen by the bridge.
// Modports : slave  - the bridge (drives ack/dataout/decode and the
//                     controller request side)
//            master - the environment (Xbus master plus SDRAM controller)
// Revision : 1.0 - initial release
// ============================================================================
interface xbus_sdram_bridge_if
   import xbus_sdram_bridge_pkg::*;
#(
   parameter int ADDR_W = XBUS_ADDR_W,
   parameter int DATA_W = XBUS_DATA_W
) ();

   // Xbus side
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] datain;
   logic              req;
   logic              write;
   logic [DATA_W-1:0] dataout;
   logic              ack;
   logic              decode;

   // SDRAM controller side
   logic [ADDR_W-1:0] sdram_addr;
   logic [DATA_W-1:0] sdram_data_out;
   logic [DATA_W-1:0] sdram_data_in;
   logic              sdram_req;
   logic              sdram_write;
   logic              sdram_ready;
   logic              sdram_done;

   // Status
   logic              timeout_err;

   modport slave (
      input  addr, datain, req, write,
      output dataout, ack, decode,
      output sdram_addr, sdram_data_out, sdram_req, sdram_write,
      input  sdram_data_in, sdram_ready, sdram_done,
      output timeout_err
   );

   modport master (
      output addr, datain, req, write,
      input  dataout, ack, decode,
      input  sdram_addr, sdram_data_out, sdram_req, sdram_write,
      output sdram_data_in, sdram_ready, sdram_done,
      input  timeout_err
   );

endinterface
`default_nettype wire

// File: rtl/xbus_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : xbus_watchdog
// Purpose  : Cycle counter that flags when a wait has lasted i_limit cycles.
//            The count clears on i_clear and advances on every enabled cycle
//            (saturating). o_expire is asserted combinationally during the
//            cycle whose closing edge is the i_limit-th enabled edge.
// Ports    : clk, reset_n        - clock, async active-low reset
//            i_clear             - zero the count (start of a new wait)
//            i_enable            - count this cycle
//            i_limit[CNT_W]      - number of enabled edges allowed (>= 1)
//            o_expire            - the current enabled edge reaches i_limit
// Revision : 1.0 - initial release
// ============================================================================
module xbus_watchdog
   import xbus_sdram_bridge_pkg::*;
#(
   parameter int CNT_W = XBUS_WDOG_W
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   input  wire logic             i_clear,
   input  wire logic             i_enable,
   input  wire logic [CNT_W-1:0] i_limit,
   output logic                  o_expire
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   // r_count holds the number of enabled edges already taken, so the edge
   // that would bring it to i_limit is the one that expires.
   assign o_expire = i_enable && (r_count >= (i_limit - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/xbus_sdram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : xbus_sdram_bridge
// Purpose  : Xbus main-memory slave backed by an SDRAM controller. Accepts a
//            decoded request, latches it, runs one read or write handshake on
//            the controller port and returns a single-cycle ack with
//            registered read data. Decoded addresses at or above RAM_LIMIT
//            are answered locally (reads return all-ones). A watchdog turns a
//            stalled controller into an all-ones ack flagged by timeout_err.
// Ports    : clk         - clock, rising edge
//            reset_n     - asynchronous active-low reset
//            io_bus      - xbus_sdram_bridge_if.slave: Xbus addr/datain/req/
//                          write/dataout/ack/decode, controller sdram_* and
//                          timeout_err
// Revision : 1.0 - initial release
// ============================================================================
module xbus_sdram_bridge
   import xbus_sdram_bridge_pkg::*;
#(
   parameter int                ADDR_W       = XBUS_ADDR_W,
   parameter int                DATA_W       = XBUS_DATA_W,
   parameter logic [ADDR_W-1:0] DECODE_LIMIT = ADDR_W'(XBUS_DECODE_LIMIT),
   parameter logic [ADDR_W-1:0] RAM_LIMIT    = ADDR_W'(XBUS_RAM_LIMIT),
   parameter int                TIMEOUT      = XBUS_TIMEOUT
) (
   input  wire logic          clk,
   input  wire logic          reset_n,
   xbus_sdram_bridge_if.slave io_bus
);

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   state_t            r_state;
   state_t            w_next_state;

   logic [DATA_W-1:0] r_dataout;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_write;
   logic              r_timeout;

   logic              w_decode;
   logic              w_accept;
   logic              w_in_ram;
   logic              w_done_hit;
   logic              w_timeout_hit;
   logic              w_wdog_en;
   logic              w_expire;

   logic              w_sdram_req;
   logic              w_ack;
   logic              w_timeout_err;

   // ------------------------------------------------------------------------
   // Decode and transaction qualifiers
   // ------------------------------------------------------------------------
   assign w_decode  = (io_bus.addr < DECODE_LIMIT);
   assign w_accept  = (r_state == ST_IDLE) && io_bus.req && w_decode;
   assign w_in_ram  = (io_bus.addr < RAM_LIMIT);

   // Controller completion: done together with ready while still issuing, or
   // done alone once the request has been taken.
   assign w_done_hit = ((r_state == ST_ISSUE) && io_bus.sdram_ready && io_bus.sdram_done)
                    || ((r_state == ST_WAIT)  && io_bus.sdram_done);

   // Completion wins over the watchdog on the same edge.
   assign w_wdog_en     = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
   assign w_timeout_hit = w_wdog_en && w_expire && !w_done_hit;

   // ------------------------------------------------------------------------
   // Watchdog
   // ------------------------------------------------------------------------
   xbus_watchdog #(
      .CNT_W    (XBUS_WDOG_W)
   ) u_watchdog (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_clear  (w_accept),
      .i_enable (w_wdog_en),
      .i_limit  (XBUS_WDOG_W'(TIMEOUT)),
      .o_expire (w_expire)
   );

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next_state = w_in_ram ? ST_ISSUE : ST_ACK;
            end
         end
         ST_ISSUE: begin
            if (w_done_hit || w_timeout_hit) begin
               w_next_state = ST_ACK;
            end else if (io_bus.sdram_ready) begin
               w_next_state = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (w_done_hit || w_timeout_hit) begin
               w_next_state = ST_ACK;
            end
         end
         ST_ACK: begin
            w_next_state = ST_HOLD;
         end
         ST_HOLD: begin
            // A request still held from the finished transfer must not be
            // taken again; wait for it to drop.
            if (!io_bus.req) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_sdram_req   = 1'b0;
      w_ack         = 1'b0;
      w_timeout_err = 1'b0;
      case (r_state)
         ST_ISSUE: begin
            w_sdram_req = 1'b1;
         end
         ST_ACK: begin
            w_ack         = 1'b1;
            w_timeout_err = r_timeout;
         end
         default: begin
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath: request latch, read data and timeout flag
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_write   <= 1'b0;
         r_dataout <= '0;
         r_timeout <= 1'b0;
      end else begin
         // Only high for the ACK cycle that follows a watchdog expiry.
         r_timeout <= w_timeout_hit;

         if (w_accept) begin
            r_addr  <= io_bus.addr;
            r_wdata <= io_bus.datain;
            r_write <= io_bus.write;
            // Unpopulated but decoded: answer a read with all-ones locally.
            if (!w_in_ram && !io_bus.write) begin
               r_dataout <= '1;
            end
         end

         if (w_timeout_hit) begin
            r_dataout <= '1;
         end else if (w_done_hit && !r_write) begin
            r_dataout <= io_bus.sdram_data_in;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output assignments
   // ------------------------------------------------------------------------
   assign io_bus.decode         = w_decode;
   assign io_bus.dataout        = r_dataout;
   assign io_bus.ack            = w_ack;
   assign io_bus.sdram_addr     = r_addr;
   assign io_bus.sdram_data_out = r_wdata;
   assign io_bus.sdram_write    = r_write;
   assign io_bus.sdram_req      = w_sdram_req;
   assign io_bus.timeout_err    = w_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_xbus_sdram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_xbus_sdram_bridge
// Purpose  : Directed self-checking bench for xbus_sdram_bridge. Each task
//            drives one scenario (Xbus master plus a scripted SDRAM
//            controller) and compares the observed behaviour against
//            hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xbus_sdram_bridge;

   localparam int ADDR_W  = 22;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 255;

   logic clk;
   logic reset_n;

   int checks = 0;
   int errors = 0;

   // Observations collected by xfer()
   int          ack_edge;
   int          ack_cnt;
   int          to_cnt;
   int          sreq_cnt;
   int          hs_cnt;
   logic [31:0] ack_data;
   logic        ack_to;
   logic        stable;

   xbus_sdram_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   xbus_sdram_bridge #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .DECODE_LIMIT (22'h24_0000),
      .RAM_LIMIT    (22'h20_0000),
      .TIMEOUT      (TIMEOUT)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .io_bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one Xbus transaction. Edge 0 is the first rising edge with req
   // high. The controller raises ready before edge ready_at and done before
   // edge done_at (-1 = never). req is dropped hold edges after the ack edge.
   // After the accept edge the Xbus inputs are scrambled to show that only
   // the latched copy matters.
   task automatic xfer(input logic [21:0] a, input logic [31:0] d, input logic w,
                       input int ready_at, input int done_at, input logic [31:0] rd,
                       input int hold, input int win);
      int stop;
      ack_edge = -1; ack_cnt = 0; to_cnt = 0; sreq_cnt = 0; hs_cnt = 0;
      ack_data = '0; ack_to = 1'b0; stable = 1'b1;
      stop = win;
      bus.addr = a; bus.datain = d; bus.write = w; bus.req = 1'b1;
      bus.sdram_data_in = rd;
      for (int e = 0; e < stop; e++) begin
         bus.sdram_ready = (e == ready_at);
         bus.sdram_done  = (e == done_at);
         if (bus.sdram_req && bus.sdram_ready) hs_cnt++;
         step();
         if (e == 0) begin
            bus.addr = a ^ 22'h1; bus.datain = ~d; bus.write = ~w;
         end
         if (bus.sdram_req)   sreq_cnt++;
         if (bus.timeout_err) to_cnt++;
         if (ack_edge < 0 || e == ack_edge) begin
            if (bus.sdram_addr !== a || bus.sdram_data_out !== d || bus.sdram_write !== w)
               stable = 1'b0;
         end
         if (bus.ack) begin
            ack_cnt++;
            if (ack_edge < 0) begin
               ack_edge = e; ack_data = bus.dataout; ack_to = bus.timeout_err;
               stop = e + hold + 3;
            end
         end
         if (ack_edge >= 0 && e == ack_edge + hold) bus.req = 1'b0;
      end
      bus.req = 1'b0; bus.sdram_ready = 1'b0; bus.sdram_done = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.addr = '0; bus.datain = '0; bus.req = 1'b0; bus.write = 1'b0;
      bus.sdram_data_in = '0; bus.sdram_ready = 1'b0; bus.sdram_done = 1'b0;
      repeat (3) step();
      checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus.ack); end
      checks++; if (bus.sdram_req !== 1'b0) begin errors++; $display("FAIL reset_sdram_req: got %b expected 0", bus.sdram_req); end
      checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", bus.timeout_err); end
      checks++; if (bus.dataout !== 32'h0) begin errors++; $display("FAIL reset_dataout: got %h expected 0", bus.dataout); end
      checks++; if (bus.sdram_addr !== 22'h0) begin errors++; $display("FAIL reset_sdram_addr: got %h expected 0", bus.sdram_addr); end
      checks++; if (bus.sdram_data_out !== 32'h0) begin errors++; $display("FAIL reset_sdram_data_out: got %h expected 0", bus.sdram_data_out); end
      checks++; if (bus.sdram_write !== 1'b0) begin errors++; $display("FAIL reset_sdram_write: got %b expected 0", bus.sdram_write); end
      checks++; if (bus.decode !== 1'b1) begin errors++; $display("FAIL reset_decode: got %b expected 1", bus.decode); end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_read();
      xfer(22'o1234, 32'h0, 1'b0, 1, 4, 32'hDEAD_BEEF, 0, 20);
      checks++; if (ack_edge !== 4) begin errors++; $display("FAIL read_ack_edge: got %0d expected 4", ack_edge); end
      checks++; if (ack_cnt !== 1) begin errors++; $display("FAIL read_ack_count: got %0d expected 1", ack_cnt); end
      checks++; if (ack_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data: got %h expected deadbeef", ack_data); end
      checks++; if (to_cnt !== 0) begin errors++; $display("FAIL read_timeout_err: got %0d expected 0", to_cnt); end
      checks++; if (hs_cnt !== 1) begin errors++; $display("FAIL read_handshakes: got %0d expected 1", hs_cnt); end
      checks++; if (stable !== 1'b1) begin errors++; $display("FAIL read_latched_request: got %b expected 1", stable); end
   endtask

   task automatic test_write();
      xfer(22'o77, 32'h1234_5678, 1'b1, 2, 5, 32'h5555_5555, 0, 20);
      checks++; if (ack_edge !== 5) begin errors++; $display("FAIL write_ack_edge: got %0d expected 5", ack_edge); end
      checks++; if (ack_cnt !== 1) begin errors++; $display("FAIL write_ack_count: got %0d expected 1", ack_cnt); end
      checks++; if (stable !== 1'b1) begin errors++; $display("FAIL write_latched_request: got %b expected 1", stable); end
      checks++; if (hs_cnt !== 1) begin errors++; $display("FAIL write_handshakes: got %0d expected 1", hs_cnt); end
      checks++; if (to_cnt !== 0) begin errors++; $display("FAIL write_timeout_err: got %0d expected 0", to_cnt); end
   endtask

   task automatic test_min_latency();
      // Top populated word, ready and done together at the first ISSUE edge.
      xfer(22'h1F_FFFF, 32'h0, 1'b0, 1, 1, 32'hA5A5_5A5A, 0, 10);
      checks++; if (ack_edge !== 1) begin errors++; $display("FAIL minlat_ack_edge: got %0d expected 1", ack_edge); end
      checks++; if (ack_data !== 32'hA5A5_5A5A) begin errors++; $display("FAIL minlat_data: got %h expected a5a55a5a", ack_data); end
      checks++; if (hs_cnt !== 1) begin errors++; $display("FAIL minlat_handshakes: got %0d expected 1", hs_cnt); end
   endtask

   task automatic test_out_of_range();
      // octal 10500000: decoded but above the populated RAM
      xfer(22'h22_8000, 32'h0, 1'b0, -1, -1, 32'h0, 0, 10);
      checks++; if (ack_edge !== 0) begin errors++; $display("FAIL oor_ack_edge: got %0d expected 0", ack_edge); end
      checks++; if (ack_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL oor_data: got %h expected ffffffff", ack_data); end
      checks++; if (sreq_cnt !== 0) begin errors++; $display("FAIL oor_sdram_req: got %0d expected 0", sreq_cnt); end
      checks++; if (ack_cnt !== 1) begin errors++; $display("FAIL oor_ack_count: got %0d expected 1", ack_cnt); end
      // Exactly RAM_LIMIT is already unpopulated.
      xfer(22'h20_0000, 32'h0, 1'b0, 1, 1, 32'h1357_9BDF, 0, 10);
      checks++; if (ack_edge !== 0) begin errors++; $display("FAIL ramlimit_ack_edge: got %0d expected 0", ack_edge); end
      checks++; if (sreq_cnt !== 0) begin errors++; $display("FAIL ramlimit_sdram_req: got %0d expected 0", sreq_cnt); end
      // Decode boundary
      bus.addr = 22'h23_FFFF; #1;
      checks++; if (bus.decode !== 1'b1) begin errors++; $display("FAIL decode_last: got %b expected 1", bus.decode); end
      bus.addr = 22'h24_0000; #1;
      checks++; if (bus.decode !== 1'b0) begin errors++; $display("FAIL decode_limit: got %b expected 0", bus.decode); end
      step();
      xfer(22'h24_0000, 32'h0, 1'b0, 1, 1, 32'h0, 0, 300);
      checks++; if (ack_cnt !== 0) begin errors++; $display("FAIL undecoded_ack_count: got %0d expected 0", ack_cnt); end
      checks++; if (sreq_cnt !== 0) begin errors++; $display("FAIL undecoded_sdram_req: got %0d expected 0", sreq_cnt); end
   endtask

   task automatic test_timeout();
      int late_acks;
      // Ready at edge 3, done never in time; a late done lands in HOLD.
      xfer(22'o4000, 32'h0, 1'b0, 3, 257, 32'h1234_5678, 5, 300);
      checks++; if (ack_edge !== TIMEOUT) begin errors++; $display("FAIL to_ack_edge: got %0d expected %0d", ack_edge, TIMEOUT); end
      checks++; if (ack_to !== 1'b1) begin errors++; $display("FAIL to_err_with_ack: got %b expected 1", ack_to); end
      checks++; if (to_cnt !== 1) begin errors++; $display("FAIL to_err_cycles: got %0d expected 1", to_cnt); end
      checks++; if (ack_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_data: got %h expected ffffffff", ack_data); end
      checks++; if (ack_cnt !== 1) begin errors++; $display("FAIL to_ack_count: got %0d expected 1", ack_cnt); end
      checks++; if (bus.dataout !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_late_done_hold: got %h expected ffffffff", bus.dataout); end
      // Late done while idle
      bus.sdram_data_in = 32'h1111_1111; bus.sdram_done = 1'b1;
      late_acks = 0;
      step();
      bus.sdram_done = 1'b0;
      if (bus.ack) late_acks++;
      repeat (3) begin step(); if (bus.ack) late_acks++; end
      checks++; if (late_acks !== 0) begin errors++; $display("FAIL to_late_done_idle_ack: got %0d expected 0", late_acks); end
      checks++; if (bus.dataout !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_late_done_idle_data: got %h expected ffffffff", bus.dataout); end
      // Controller never takes the request at all.
      xfer(22'o5000, 32'h0, 1'b1, -1, -1, 32'h0, 0, 300);
      checks++; if (ack_edge !== TIMEOUT) begin errors++; $display("FAIL to_issue_ack_edge: got %0d expected %0d", ack_edge, TIMEOUT); end
      checks++; if (ack_to !== 1'b1) begin errors++; $display("FAIL to_issue_err: got %b expected 1", ack_to); end
      checks++; if (sreq_cnt !== TIMEOUT) begin errors++; $display("FAIL to_issue_sdram_req_cycles: got %0d expected %0d", sreq_cnt, TIMEOUT); end
      checks++; if (hs_cnt !== 0) begin errors++; $display("FAIL to_issue_handshakes: got %0d expected 0", hs_cnt); end
   endtask

   task automatic test_back_to_back();
      xfer(22'o100, 32'h0, 1'b0, 1, 2, 32'h0BAD_F00D, 10, 30);
      checks++; if (ack_cnt !== 1) begin errors++; $display("FAIL held_req_ack_count: got %0d expected 1", ack_cnt); end
      checks++; if (sreq_cnt !== 1) begin errors++; $display("FAIL held_req_sdram_req_cycles: got %0d expected 1", sreq_cnt); end
      checks++; if (ack_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL held_req_data: got %h expected 0badf00d", ack_data); end
      xfer(22'o200, 32'h0, 1'b0, 1, 3, 32'hFEED_FACE, 0, 20);
      checks++; if (ack_edge !== 3) begin errors++; $display("FAIL b2b_ack_edge: got %0d expected 3", ack_edge); end
      checks++; if (ack_data !== 32'hFEED_FACE) begin errors++; $display("FAIL b2b_data: got %h expected feedface", ack_data); end
      // Issued two edges after the ACK-to-HOLD edge: must be accepted at once.
      xfer(22'o300, 32'h0, 1'b0, 1, 1, 32'h2468_ACE0, 0, 10);
      checks++; if (ack_edge !== 1) begin errors++; $display("FAIL b2b_gap_ack_edge: got %0d expected 1", ack_edge); end
      checks++; if (ack_data !== 32'h2468_ACE0) begin errors++; $display("FAIL b2b_gap_data: got %h expected 2468ace0", ack_data); end
   endtask

   task automatic test_reset_mid();
      int late_acks;
      bus.addr = 22'o3000; bus.datain = 32'hCAFE_F00D; bus.write = 1'b1; bus.req = 1'b1;
      step();                      // edge 0: accept
      bus.sdram_ready = 1'b1;
      step();                      // edge 1: taken, WAIT
      bus.sdram_ready = 1'b0;
      step();                      // edge 2: still WAIT
      checks++; if (bus.sdram_write !== 1'b1) begin errors++; $display("FAIL midrst_pre_write: got %b expected 1", bus.sdram_write); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (bus.sdram_addr !== 22'h0) begin errors++; $display("FAIL midrst_sdram_addr: got %h expected 0", bus.sdram_addr); end
      checks++; if (bus.sdram_data_out !== 32'h0) begin errors++; $display("FAIL midrst_sdram_data_out: got %h expected 0", bus.sdram_data_out); end
      checks++; if (bus.sdram_write !== 1'b0) begin errors++; $display("FAIL midrst_sdram_write: got %b expected 0", bus.sdram_write); end
      checks++; if (bus.dataout !== 32'h0) begin errors++; $display("FAIL midrst_dataout: got %h expected 0", bus.dataout); end
      checks++; if (bus.ack !== 1'b0 || bus.sdram_req !== 1'b0 || bus.timeout_err !== 1'b0) begin
         errors++; $display("FAIL midrst_strobes: got ack=%b sdram_req=%b timeout_err=%b expected all 0",
                            bus.ack, bus.sdram_req, bus.timeout_err);
      end
      step();
      reset_n = 1'b1; bus.req = 1'b0;
      bus.sdram_data_in = 32'h9999_9999; bus.sdram_done = 1'b1;
      late_acks = 0;
      step();
      bus.sdram_done = 1'b0;
      if (bus.ack) late_acks++;
      repeat (4) begin step(); if (bus.ack) late_acks++; end
      checks++; if (late_acks !== 0) begin errors++; $display("FAIL midrst_stale_done_ack: got %0d expected 0", late_acks); end
      checks++; if (bus.dataout !== 32'h0) begin errors++; $display("FAIL midrst_stale_done_data: got %h expected 0", bus.dataout); end
      xfer(22'o3000, 32'h0102_0304, 1'b0, 1, 2, 32'h3141_5926, 0, 10);
      checks++; if (ack_edge !== 2) begin errors++; $display("FAIL midrst_recover_ack_edge: got %0d expected 2", ack_edge); end
      checks++; if (ack_data !== 32'h3141_5926) begin errors++; $display("FAIL midrst_recover_data: got %h expected 31415926", ack_data); end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_min_latency();
      test_out_of_range();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/xbus_sdram_bridge.md
# xbus_sdram_bridge

Parametrised Xbus memory slave that replaces the fixed-latency simulation RAM with a real SDRAM-controller handshake. It decodes a configurable main-memory window on the Xbus and latches each accepted transaction. It then runs a single read or write on the SDRAM controller port and returns a one-cycle `ack` with registered read data. Decoded addresses above the populated limit are answered locally: reads return all-ones and writes are discarded. A watchdog converts a hung controller into an all-ones, acknowledged, flagged cycle.

## Interface
- `ADDR_W`, 22, Xbus/SDRAM word-address width
- `DATA_W`, 32, data width
- `DECODE_LIMIT`, 22'o11000000, `decode` asserted for `addr < DECODE_LIMIT`
- `RAM_LIMIT`, 22'o10000000, populated words; `RAM_LIMIT <= DECODE_LIMIT`
- `TIMEOUT`, 255, max cycles waiting on `sdram_ready`/`sdram_done` (1..65535)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `reset_n` in 1: reset is asynchronous and active-low
- `addr` in ADDR_W: Xbus address
- `datain` in DATA_W: Xbus write data
- `req` in 1: Xbus request, held until `ack`
- `write` in 1: 1 = write, 0 = read
- `dataout` out DATA_W: registered read data, valid while `ack`=1
- `ack` out 1: one-cycle completion pulse
- `decode` out 1: combinational, `addr < DECODE_LIMIT`
- `sdram_addr` out ADDR_W: latched address
- `sdram_data_out` out DATA_W: latched write data
- `sdram_data_in` in DATA_W: read data, valid with `sdram_done`
- `sdram_req` out 1: request to controller
- `sdram_write` out 1: latched `write`
- `sdram_ready` in 1: controller accepted request
- `sdram_done` in 1: controller finished; read data valid
- `timeout_err` out 1: one-cycle pulse coincident with a timed-out `ack`

## Operation
- States: IDLE, ISSUE, WAIT, ACK, HOLD.
- IDLE: on a rising edge with `req & decode`, latch `addr`, `datain` and `write`.
  - If `addr < RAM_LIMIT`, go to ISSUE.
  - Otherwise go to ACK with `dataout` = all-ones (for a read) and no SDRAM activity.
- ISSUE: `sdram_req`=1. Leave when `sdram_ready`=1 sampled:
  - to WAIT normally;
  - directly to ACK if `sdram_done`=1 in the same cycle.
- WAIT: `sdram_req`=0. On `sdram_done`, a read captures `sdram_data_in` into `dataout`; then go to ACK.
- Watchdog:
  - A 16-bit counter clears on entry to ISSUE and counts during ISSUE and WAIT.
  - When it reaches `TIMEOUT` with no `sdram_done`, go to ACK with `dataout` = all-ones, pulse `timeout_err`, and drop `sdram_req`.
- ACK: `ack`=1 for exactly one cycle, then go to HOLD.
- HOLD: wait for `req`=0, then go to IDLE. This prevents a held `req` from being accepted twice.
- `sdram_addr`, `sdram_data_out` and `sdram_write` are stable from ISSUE entry until ACK.
- A late `sdram_done` arriving in ACK, HOLD or IDLE after a timeout is ignored.
- `write` is latched at accept; changes on `write`, `addr` or `datain` after accept have no effect.
- Reset (`reset_n`=0, any state, including mid-ISSUE or mid-WAIT):
  - state returns to IDLE immediately;
  - `ack`, `sdram_req`, `timeout_err` and counters = 0;
  - `dataout`, `sdram_addr`, `sdram_data_out` = 0; `sdram_write` = 0.
- `decode` is not reset-dependent.

## Timing
- Edge numbering: `req` is sampled at edge 0 in IDLE. `sdram_req`=1 from edge 0 until the edge that samples `sdram_ready`.
- Minimum latency: ready and done both at the first ISSUE edge gives `ack` high after edge 1, i.e. 2 cycles.
- Typical: ready at edge 1, done at edge k gives `ack` after edge k.
- Out-of-range access: `ack` after edge 0 (1 cycle).
- Timeout: `ack` and `timeout_err` after edge `TIMEOUT`.
- Next accept: no earlier than the edge after `req` is seen low in HOLD. With `req` dropped during ACK, the next accept is 2 edges after the ACK edge.

## Structure
- The shared Xbus package holds:
  - the state enum;
  - `XBUS_ADDR_W` and `XBUS_DATA_W`;
  - the default `DECODE_LIMIT` and `RAM_LIMIT` constants.
- The watchdog counter is a natural sub-module, `xbus_watchdog` (clear, enable, limit → expire). Everything else stays flat.

## Test plan
- Read `addr`=0o1234, controller returns `sdram_data_in`=0xDEADBEEF with ready at edge 1 and done at edge 4 → `sdram_addr`=0o1234, `sdram_write`=0, single `ack` with `dataout`=0xDEADBEEF, `timeout_err`=0.
- Write `addr`=0o77, `datain`=0x12345678 → `sdram_write`=1, `sdram_data_out`=0x12345678 stable until `ack`; `ack` 1 cycle after `sdram_done`.
- Read `addr`=0o10500000 (decoded, ≥ RAM_LIMIT) → `ack` after 1 cycle, `dataout`=0xFFFFFFFF, `sdram_req` never asserted. Read `addr`=0o11000000 → `decode`=0, no `ack` for 300 cycles.
- Controller never asserts `sdram_done`, `TIMEOUT`=255 → `ack` and `timeout_err` together 255 cycles after accept, `dataout`=all-ones. A later `sdram_done` is ignored.
- `req` held high 10 cycles after `ack` → exactly one `ack` and one `sdram_req` handshake. A back-to-back request after `req` drops is accepted normally.
- `reset_n` pulsed low during WAIT → all outputs 0 asynchronously; the stale `sdram_done` afterwards produces no `ack`; the next request completes normally.
